// File: rtl/video_pkg.sv
// Shared definitions for the pixel-domain pattern generator: timing-bundle bit
// positions, pattern modes and colour constants.
package video_pkg;

  localparam int HVE_HSYNC = 0;
  localparam int HVE_VSYNC = 1;
  localparam int HVE_DE    = 2;

  typedef enum logic [1:0] {
    PAT_XOR     = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_SCROLL  = 2'd3
  } pat_mode_e;

  localparam logic [23:0] RGB_WHITE = 24'hFF_FF_FF;
  localparam logic [23:0] RGB_BLACK = 24'h00_00_00;

  // Index 0 sits in the least significant slot: white on the left of the screen.
  localparam logic [7:0][23:0] COLOR_BARS = {
    24'h00_00_00,  // 7 black
    24'h00_00_FF,  // 6 blue
    24'hFF_00_00,  // 5 red
    24'hFF_00_FF,  // 4 magenta
    24'h00_FF_00,  // 3 green
    24'h00_FF_FF,  // 2 cyan
    24'hFF_FF_00,  // 1 yellow
    24'hFF_FF_FF   // 0 white
  };

endpackage

// File: rtl/video_pattern_color.sv
// Combinational colour selection for one pixel: blanking, then border, then the
// active test pattern.
module video_pattern_color
  import video_pkg::*;
#(
  parameter int BAR_SHIFT = 7
) (
  input  pat_mode_e   mode,
  input  logic [12:0] x,
  input  logic [12:0] y,
  input  logic [7:0]  frame,
  input  logic        de,
  input  logic        border,
  output logic [23:0] rgb
);

  logic [2:0] bar_idx;
  logic [7:0] scroll_r;
  logic [7:0] scroll_g;
  logic       unused_bits;

  assign bar_idx  = x[BAR_SHIFT+2:BAR_SHIFT];
  assign scroll_r = x[7:0] + frame;
  assign scroll_g = y[7:0] + frame;

  // Upper coordinate bits only matter to the border compare in the top.
  assign unused_bits = ^{x, y};

  always_comb begin
    // NOTE: default first so every path assigns rgb and no latch is inferred.
    rgb = RGB_BLACK;
    if (de) begin
      if (border) begin
        rgb = RGB_WHITE;
      end else begin
        case (mode)
          PAT_XOR:     rgb = {x[7:0], y[7:0], x[7:0] ^ y[7:0]};
          PAT_BARS:    rgb = COLOR_BARS[bar_idx];
          PAT_CHECKER: rgb = (x[4] ^ y[4]) ? RGB_WHITE : RGB_BLACK;
          PAT_SCROLL:  rgb = {scroll_r, scroll_g, frame};
          default:     rgb = RGB_BLACK;
        endcase
      end
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern source between the timing generator and the TMDS stage: two-stage
// pipeline with frame-synchronous mode switching and an 8-bit frame counter.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_RESOLUTION    = 1024,
  parameter int V_RESOLUTION    = 768,
  parameter bit V_SYNC_POLARITY = 1'b0,
  parameter bit H_SYNC_POLARITY = 1'b0,
  parameter int BAR_SHIFT       = 7,
  parameter bit BORDER_EN       = 1'b1
) (
  input  logic        i_pixel_clk,
  input  logic        i_resetn,
  input  logic [2:0]  i_hve,
  input  logic [12:0] i_x,
  input  logic [12:0] i_y,
  input  logic [1:0]  i_mode,
  output logic [2:0]  o_hve,
  output logic [23:0] o_rgb,
  output logic [7:0]  o_frame
);

  localparam logic [2:0]  HVE_IDLE = {1'b0, ~V_SYNC_POLARITY, ~H_SYNC_POLARITY};
  localparam logic [12:0] X_LAST   = 13'(H_RESOLUTION - 1);
  localparam logic [12:0] Y_LAST   = 13'(V_RESOLUTION - 1);

  logic [2:0]  hve_s1;
  logic [12:0] x_s1;
  logic [12:0] y_s1;
  logic        frame_start_s1;
  logic        vsync_prev;
  pat_mode_e   pending_mode;
  pat_mode_e   active_mode;
  logic [7:0]  frame_cnt;
  logic        vsync_active;
  logic        border_hit;
  logic [23:0] rgb_next;

  assign vsync_active = (i_hve[HVE_VSYNC] == V_SYNC_POLARITY);

  // Stage 1: timing capture, frame-start edge detect and mode request sampling.
  always_ff @(posedge i_pixel_clk or negedge i_resetn) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!i_resetn) begin
      hve_s1         <= HVE_IDLE;
      x_s1           <= '0;
      y_s1           <= '0;
      frame_start_s1 <= 1'b0;
      vsync_prev     <= ~V_SYNC_POLARITY;
      pending_mode   <= PAT_XOR;
    end else begin
      hve_s1         <= i_hve;
      x_s1           <= i_x;
      y_s1           <= i_y;
      frame_start_s1 <= vsync_active && (vsync_prev != V_SYNC_POLARITY);
      vsync_prev     <= i_hve[HVE_VSYNC];
      pending_mode   <= pat_mode_e'(i_mode);
    end
  end

  // Mode and frame count only move at a frame start, so a frame is never split.
  always_ff @(posedge i_pixel_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      active_mode <= PAT_XOR;
      frame_cnt   <= '0;
    end else if (frame_start_s1) begin
      active_mode <= pending_mode;
      frame_cnt   <= frame_cnt + 8'd1;
    end
  end

  assign border_hit = BORDER_EN &&
                      (x_s1 == '0 || x_s1 == X_LAST || y_s1 == '0 || y_s1 == Y_LAST);

  video_pattern_color #(
    .BAR_SHIFT(BAR_SHIFT)
  ) u_color (
    .mode  (active_mode),
    .x     (x_s1),
    .y     (y_s1),
    .frame (frame_cnt),
    .de    (hve_s1[HVE_DE]),
    .border(border_hit),
    .rgb   (rgb_next)
  );

  // Stage 2: colour and its delay-matched timing leave together.
  always_ff @(posedge i_pixel_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_hve <= HVE_IDLE;
      o_rgb <= RGB_BLACK;
    end else begin
      o_hve <= hve_s1;
      o_rgb <= rgb_next;
    end
  end

  assign o_frame = frame_cnt;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen: two instances (border off / on)
// driven in lockstep and compared against a behavioural event model.
module tb_video_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  hve;
  logic [12:0] x;
  logic [12:0] y;
  logic [1:0]  mode;

  logic [2:0]  o_hve_a, o_hve_b;
  logic [23:0] o_rgb_a, o_rgb_b;
  logic [7:0]  o_frame_a, o_frame_b;

  always #5 clk = ~clk;

  video_pattern_gen #(.BORDER_EN(1'b0)) dut_a (
    .i_pixel_clk(clk), .i_resetn(rst_n), .i_hve(hve), .i_x(x), .i_y(y), .i_mode(mode),
    .o_hve(o_hve_a), .o_rgb(o_rgb_a), .o_frame(o_frame_a)
  );

  video_pattern_gen #(.BORDER_EN(1'b1)) dut_b (
    .i_pixel_clk(clk), .i_resetn(rst_n), .i_hve(hve), .i_x(x), .i_y(y), .i_mode(mode),
    .o_hve(o_hve_b), .o_rgb(o_rgb_b), .o_frame(o_frame_b)
  );

  typedef struct {
    logic [2:0]  hve;
    logic [23:0] rgb_a;
    logic [23:0] rgb_b;
    logic [7:0]  frame;
  } exp_t;

  typedef struct {
    logic [2:0] h;
    int x;
    int y;
    int md;
    int lit_a;
    int lit_b;
  } stim_t;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t cur;
  bit   cur_valid;

  // Model state: frame-start bookkeeping as seen by the pixel stream.
  bit m_prev_vs;
  bit m_fs_last;
  int m_fs_mode;
  int m_mode;
  int m_frame;

  function automatic logic [23:0] model_rgb(int md, int xm, int ym, int fr, bit de, bit border_en);
    int idx, r, g, b;
    r = 0; g = 0; b = 0;
    if (!de) return 24'h0;
    if (border_en && (xm == 0 || xm == 1023 || ym == 0 || ym == 767)) return 24'hFFFFFF;
    case (md)
      0: begin r = xm % 256; g = ym % 256; b = r ^ g; end
      1: begin
        idx = (xm / 128) % 8;
        r = ((idx / 2) % 2 == 0) ? 255 : 0;
        g = (idx < 4) ? 255 : 0;
        b = (idx % 2 == 0) ? 255 : 0;
      end
      2: begin r = (((xm / 16) + (ym / 16)) % 2 == 1) ? 255 : 0; g = r; b = r; end
      default: begin r = (xm + fr) % 256; g = (ym + fr) % 256; b = fr; end
    endcase
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back('{hve: 3'b011, rgb_a: 24'h0, rgb_b: 24'h0, frame: 8'h0});
    m_prev_vs = 1'b0;
    m_fs_last = 1'b0;
    m_fs_mode = 0;
    m_mode    = 0;
    m_frame   = 0;
  endtask

  // Drive one pixel cycle, predict its output, then expose the output due now.
  task automatic step(input logic [2:0] h, input int xi, input int yi, input int md);
    exp_t e;
    bit   vs_act, is_fs;
    int   xm, ym;
    hve  = h;
    x    = xi[12:0];
    y    = yi[12:0];
    mode = md[1:0];
    xm = xi & 'h1FFF;
    ym = yi & 'h1FFF;
    if (m_fs_last) begin
      m_mode  = m_fs_mode;
      m_frame = (m_frame + 1) % 256;
    end
    vs_act    = (h[1] == 1'b0);
    is_fs     = vs_act && !m_prev_vs;
    m_prev_vs = vs_act;
    m_fs_last = is_fs;
    m_fs_mode = md & 3;
    e.hve   = h;
    e.rgb_a = model_rgb(m_mode, xm, ym, m_frame, h[2], 1'b0);
    e.rgb_b = model_rgb(m_mode, xm, ym, m_frame, h[2], 1'b1);
    e.frame = 8'((m_frame + (is_fs ? 1 : 0)) % 256);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cur_valid = 1'b0;
    if (exp_q.size() >= 2) begin
      cur       = exp_q.pop_front();
      cur_valid = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hve = 3'b011; x = '0; y = '0; mode = '0;
    #7;
    checks++;
    if (o_hve_a !== 3'b011 || o_rgb_a !== 24'h0 || o_frame_a !== 8'h0) begin
      errors++;
      $display("FAIL reset_a: got hve=%b rgb=%h frame=%0d, want hve=011 rgb=000000 frame=0", o_hve_a, o_rgb_a, o_frame_a);
    end
    checks++;
    if (o_hve_b !== 3'b011 || o_rgb_b !== 24'h0 || o_frame_b !== 8'h0) begin
      errors++;
      $display("FAIL reset_b: got hve=%b rgb=%h frame=%0d, want hve=011 rgb=000000 frame=0", o_hve_b, o_rgb_b, o_frame_b);
    end
    model_reset();
    #15 rst_n = 1'b1;
  endtask

  task automatic test_xor_basic();
    for (int i = 0; i < 4; i++) begin
      step(3'b100, 'h12, 'h34, 0);
      if (cur_valid) begin
        checks++;
        if (o_hve_a !== cur.hve || o_rgb_a !== cur.rgb_a || o_frame_a !== cur.frame ||
            o_hve_b !== cur.hve || o_rgb_b !== cur.rgb_b || o_frame_b !== cur.frame) begin
          errors++;
          $display("FAIL xor_basic t=%0t: got hve=%b/%b rgb=%h/%h frame=%0d/%0d, want hve=%b rgb=%h/%h frame=%0d",
                   $time, o_hve_a, o_hve_b, o_rgb_a, o_rgb_b, o_frame_a, o_frame_b, cur.hve, cur.rgb_a, cur.rgb_b, cur.frame);
        end
      end
      if (i >= 1) begin
        checks++;
        if (o_rgb_a !== 24'h123426 || o_hve_a !== 3'b100) begin
          errors++;
          $display("FAIL xor_literal: got hve=%b rgb=%h, want hve=100 rgb=123426", o_hve_a, o_rgb_a);
        end
      end
    end
    step(3'b011, 0, 0, 0);
  endtask

  task automatic test_frame_counter();
    for (int f = 0; f < 258; f++) begin
      for (int c = 0; c < 4; c++) begin
        step((c == 0) ? 3'b001 : 3'b011, 0, 0, 0);
        if (cur_valid) begin
          checks++;
          if (o_hve_a !== cur.hve || o_rgb_a !== cur.rgb_a || o_frame_a !== cur.frame ||
              o_hve_b !== cur.hve || o_rgb_b !== cur.rgb_b || o_frame_b !== cur.frame) begin
            errors++;
            $display("FAIL frame_counter f=%0d c=%0d: got hve=%b rgb=%h frame=%0d/%0d, want hve=%b rgb=%h frame=%0d",
                     f, c, o_hve_a, o_rgb_a, o_frame_a, o_frame_b, cur.hve, cur.rgb_a, cur.frame);
          end
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    stim_t tbl[$] = '{
      '{3'b001, 0,     0, 0, -1,         -1},
      '{3'b011, 0,     0, 0, -1,         -1},
      '{3'b111, 0,     5, 0, 'h000505,   -1},
      '{3'b111, 'h380, 5, 1, 'h800585,   -1},
      '{3'b111, 0,     5, 1, 'h000505,   -1},
      '{3'b011, 0,     0, 1, -1,         -1},
      '{3'b001, 0,     0, 1, -1,         -1},
      '{3'b011, 0,     0, 1, -1,         -1},
      '{3'b111, 0,     5, 1, 'hFFFFFF,   -1},
      '{3'b111, 'h380, 5, 1, 'h000000,   -1}
    };
    for (int i = 0; i <= tbl.size(); i++) begin
      if (i < tbl.size()) step(tbl[i].h, tbl[i].x, tbl[i].y, tbl[i].md);
      else                step(3'b011, 0, 0, 1);
      if (cur_valid) begin
        checks++;
        if (o_hve_a !== cur.hve || o_rgb_a !== cur.rgb_a || o_frame_a !== cur.frame ||
            o_hve_b !== cur.hve || o_rgb_b !== cur.rgb_b || o_frame_b !== cur.frame) begin
          errors++;
          $display("FAIL mode_switch i=%0d: got hve=%b rgb=%h/%h frame=%0d, want hve=%b rgb=%h/%h frame=%0d",
                   i, o_hve_a, o_rgb_a, o_rgb_b, o_frame_a, cur.hve, cur.rgb_a, cur.rgb_b, cur.frame);
        end
      end
      if (i > 0 && tbl[i-1].lit_a >= 0) begin
        checks++;
        if (o_rgb_a !== 24'(tbl[i-1].lit_a)) begin
          errors++;
          $display("FAIL mode_switch_literal i=%0d: got rgb=%h, want %h", i - 1, o_rgb_a, 24'(tbl[i-1].lit_a));
        end
      end
    end
  endtask

  task automatic test_checker_blank();
    stim_t tbl[$] = '{
      '{3'b001, 0,    0,    2, -1,        -1},
      '{3'b011, 0,    0,    2, -1,        -1},
      '{3'b111, 'h10, 0,    2, 'hFFFFFF,  'hFFFFFF},
      '{3'b111, 'h10, 'h10, 2, 'h000000,  'h000000},
      '{3'b011, 'h10, 0,    2, 'h000000,  'h000000},
      '{3'b011, 'h10, 'h10, 2, 'h000000,  'h000000}
    };
    for (int i = 0; i <= tbl.size(); i++) begin
      if (i < tbl.size()) step(tbl[i].h, tbl[i].x, tbl[i].y, tbl[i].md);
      else                step(3'b011, 0, 0, 2);
      if (cur_valid) begin
        checks++;
        if (o_hve_a !== cur.hve || o_rgb_a !== cur.rgb_a || o_frame_a !== cur.frame ||
            o_hve_b !== cur.hve || o_rgb_b !== cur.rgb_b || o_frame_b !== cur.frame) begin
          errors++;
          $display("FAIL checker i=%0d: got hve=%b rgb=%h/%h frame=%0d, want hve=%b rgb=%h/%h frame=%0d",
                   i, o_hve_a, o_rgb_a, o_rgb_b, o_frame_a, cur.hve, cur.rgb_a, cur.rgb_b, cur.frame);
        end
      end
      if (i > 0 && tbl[i-1].lit_a >= 0) begin
        checks++;
        if (o_rgb_a !== 24'(tbl[i-1].lit_a) || o_rgb_b !== 24'(tbl[i-1].lit_b)) begin
          errors++;
          $display("FAIL checker_literal i=%0d: got rgb=%h/%h, want %h/%h",
                   i - 1, o_rgb_a, o_rgb_b, 24'(tbl[i-1].lit_a), 24'(tbl[i-1].lit_b));
        end
      end
    end
  endtask

  task automatic test_border();
    stim_t tbl[$] = '{
      '{3'b001, 0,    0,   2, -1,        -1},
      '{3'b011, 0,    0,   2, -1,        -1},
      '{3'b111, 1023, 5,   2, 'hFFFFFF,  'hFFFFFF},
      '{3'b111, 512,  767, 2, 'hFFFFFF,  'hFFFFFF},
      '{3'b111, 5,    5,   2, 'h000000,  'h000000},
      '{3'b111, 1024, 5,   2, 'h000000,  'h000000},
      '{3'b111, 0,    5,   2, 'h000000,  'hFFFFFF}
    };
    for (int i = 0; i <= tbl.size(); i++) begin
      if (i < tbl.size()) step(tbl[i].h, tbl[i].x, tbl[i].y, tbl[i].md);
      else                step(3'b011, 0, 0, 2);
      if (cur_valid) begin
        checks++;
        if (o_hve_a !== cur.hve || o_rgb_a !== cur.rgb_a || o_frame_a !== cur.frame ||
            o_hve_b !== cur.hve || o_rgb_b !== cur.rgb_b || o_frame_b !== cur.frame) begin
          errors++;
          $display("FAIL border i=%0d: got hve=%b rgb=%h/%h frame=%0d, want hve=%b rgb=%h/%h frame=%0d",
                   i, o_hve_a, o_rgb_a, o_rgb_b, o_frame_a, cur.hve, cur.rgb_a, cur.rgb_b, cur.frame);
        end
      end
      if (i > 0 && tbl[i-1].lit_b >= 0) begin
        checks++;
        if (o_rgb_a !== 24'(tbl[i-1].lit_a) || o_rgb_b !== 24'(tbl[i-1].lit_b)) begin
          errors++;
          $display("FAIL border_literal i=%0d: got rgb=%h/%h, want %h/%h",
                   i - 1, o_rgb_a, o_rgb_b, 24'(tbl[i-1].lit_a), 24'(tbl[i-1].lit_b));
        end
      end
    end
  endtask

  task automatic test_random();
    int xb[6] = '{0, 1023, 1024, 8191, 127, 128};
    int yb[5] = '{0, 767, 768, 8191, 16};
    int md = 0;
    int xi, yi;
    logic [2:0] h;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 40) == 0) h = 3'b001;
      else h = {1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1))};
      if ($urandom_range(0, 19) == 0) md = int'($urandom_range(0, 3));
      xi = ($urandom_range(0, 3) == 0) ? xb[$urandom_range(0, 5)] : int'($urandom_range(0, 8191));
      yi = ($urandom_range(0, 3) == 0) ? yb[$urandom_range(0, 4)] : int'($urandom_range(0, 8191));
      step(h, xi, yi, md);
      if (cur_valid) begin
        checks++;
        if (o_hve_a !== cur.hve || o_rgb_a !== cur.rgb_a || o_frame_a !== cur.frame ||
            o_hve_b !== cur.hve || o_rgb_b !== cur.rgb_b || o_frame_b !== cur.frame) begin
          errors++;
          $display("FAIL random i=%0d: got hve=%b/%b rgb=%h/%h frame=%0d/%0d, want hve=%b rgb=%h/%h frame=%0d",
                   i, o_hve_a, o_hve_b, o_rgb_a, o_rgb_b, o_frame_a, o_frame_b, cur.hve, cur.rgb_a, cur.rgb_b, cur.frame);
        end
      end
    end
    step(3'b011, 0, 0, md);
  endtask

  task automatic test_reset_midline();
    for (int i = 0; i < 3; i++) step(3'b111, 'h40 + i, 'h20, 3);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (o_hve_a !== 3'b011 || o_rgb_a !== 24'h0 || o_frame_a !== 8'h0 ||
        o_hve_b !== 3'b011 || o_rgb_b !== 24'h0 || o_frame_b !== 8'h0) begin
      errors++;
      $display("FAIL reset_midline: got hve=%b/%b rgb=%h/%h frame=%0d/%0d, want hve=011 rgb=000000 frame=0",
               o_hve_a, o_hve_b, o_rgb_a, o_rgb_b, o_frame_a, o_frame_b);
    end
    model_reset();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 5)       step(3'b111, 'h12, 'h34, 3);
      else if (i == 5) step(3'b001, 0, 0, 3);
      else             step(3'b111, 'h12, 'h34, 3);
      if (cur_valid) begin
        checks++;
        if (o_hve_a !== cur.hve || o_rgb_a !== cur.rgb_a || o_frame_a !== cur.frame ||
            o_hve_b !== cur.hve || o_rgb_b !== cur.rgb_b || o_frame_b !== cur.frame) begin
          errors++;
          $display("FAIL reset_release i=%0d: got hve=%b rgb=%h/%h frame=%0d, want hve=%b rgb=%h/%h frame=%0d",
                   i, o_hve_a, o_rgb_a, o_rgb_b, o_frame_a, cur.hve, cur.rgb_a, cur.rgb_b, cur.frame);
        end
      end
      if (i >= 1 && i <= 4) begin
        checks++;
        if (o_rgb_a !== 24'h123426) begin
          errors++;
          $display("FAIL reset_mode_hold i=%0d: got rgb=%h, want 123426", i, o_rgb_a);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_xor_basic();
    test_frame_counter();
    test_mode_switch();
    test_checker_blank();
    test_border();
    test_random();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
